// File: rtl/quire_to_posit_norm.sv
// Quire-to-posit normalizer: two's-complement quire -> sign, scale, fraction, guard, sticky.
// Three-stage pipeline with registered ready and a one-entry skid latch.
module quire_to_posit_norm #(
  parameter int POSIT_WIDTH    = 8,
  parameter int POSIT_ES       = 0,
  parameter int LOG_NB_ACCUM   = 10,
  parameter int FRAC_OUT_WIDTH = 5,
  localparam int NQMIN = (2 ** (POSIT_ES + 2)) * (POSIT_WIDTH - 2) + 1,
  localparam int Q     = NQMIN + LOG_NB_ACCUM,
  localparam int BPP   = (NQMIN - 1) / 2,
  localparam int SW    = $clog2(Q) + 1,
  localparam int F     = FRAC_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rts_i,
  output logic                 rtr_o,
  input  logic                 sow_i,
  input  logic                 eow_i,
  input  logic [Q-1:0]         data_i,
  input  logic                 NaR_i,
  input  logic                 rtr_i,
  output logic                 rts_o,
  output logic                 sow_o,
  output logic                 eow_o,
  output logic                 sign_o,
  output logic signed [SW-1:0] scale_o,
  output logic [F-1:0]         fraction_o,
  output logic                 guard_o,
  output logic                 sticky_o,
  output logic                 zero_o,
  output logic                 NaR_o
);
  localparam int KW = $clog2(Q);

  logic         rtr_q, pe, acc;
  logic [2:0]   vld_q;
  logic         lat_q, lat_nar_q, lat_sow_q, lat_eow_q;
  logic [Q-1:0] lat_data_q;
  logic         in_vld, in_nar, in_sow, in_eow;
  logic [Q-1:0] in_data;

  assign pe     = rtr_i | ~vld_q[2];
  assign acc    = rts_i & rtr_q;
  assign rtr_o  = rtr_q;
  assign rts_o  = vld_q[2];

  // The latched word always wins the stage-1 mux so order is preserved.
  assign in_vld  = lat_q | acc;
  assign in_data = lat_q ? lat_data_q : data_i;
  assign in_nar  = lat_q ? lat_nar_q  : NaR_i;
  assign in_sow  = lat_q ? lat_sow_q  : sow_i;
  assign in_eow  = lat_q ? lat_eow_q  : eow_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      rtr_q      <= 1'b0;
      vld_q      <= '0;
      lat_q      <= 1'b0;
      lat_data_q <= '0;
      lat_nar_q  <= 1'b0;
      lat_sow_q  <= 1'b0;
      lat_eow_q  <= 1'b0;
    end else begin
      rtr_q <= pe;
      if (pe) vld_q <= {vld_q[1:0], in_vld};
      // Capture a word that arrives during the ready lag (or while draining the latch).
      if (acc && (!pe || lat_q)) begin
        lat_q      <= 1'b1;
        lat_data_q <= data_i;
        lat_nar_q  <= NaR_i;
        lat_sow_q  <= sow_i;
        lat_eow_q  <= eow_i;
      end else if (pe) begin
        lat_q <= 1'b0;
      end
    end
  end

  // S1: sign-magnitude conversion; the most negative word maps to 2^(Q-1).
  logic         s1_sign_q, s1_nar_q, s1_sow_q, s1_eow_q;
  logic [Q-1:0] s1_mag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s1_nar_q  <= 1'b0;
      s1_sow_q  <= 1'b0;
      s1_eow_q  <= 1'b0;
    end else if (pe && in_vld) begin
      s1_sign_q <= in_data[Q-1];
      s1_mag_q  <= in_data[Q-1] ? (~in_data + 1'b1) : in_data;
      s1_nar_q  <= in_nar;
      s1_sow_q  <= in_sow;
      s1_eow_q  <= in_eow;
    end
  end

  // S2: leading-one detect.
  logic [KW-1:0] lo_k;
  always_comb begin
    lo_k = '0;
    for (int i = 0; i < Q; i++)
      if (s1_mag_q[i]) lo_k = KW'(i);
  end

  logic          s2_sign_q, s2_zero_q, s2_nar_q, s2_sow_q, s2_eow_q;
  logic [Q-1:0]  s2_mag_q;
  logic [KW-1:0] s2_k_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_nar_q  <= 1'b0;
      s2_sow_q  <= 1'b0;
      s2_eow_q  <= 1'b0;
      s2_mag_q  <= '0;
      s2_k_q    <= '0;
    end else if (pe && vld_q[0]) begin
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= (s1_mag_q == '0);
      s2_nar_q  <= s1_nar_q;
      s2_sow_q  <= s1_sow_q;
      s2_eow_q  <= s1_eow_q;
      s2_mag_q  <= s1_mag_q;
      s2_k_q    <= lo_k;
    end
  end

  // S3: the leading one shifts out of the top, leaving the bits below it left-aligned.
  logic [KW-1:0] shamt;
  logic [Q-2:0]  norm;
  logic [SW-1:0] scale_d;

  assign shamt   = KW'(Q - 1) - s2_k_q;
  assign norm    = s2_mag_q[Q-2:0] << shamt;
  assign scale_d = SW'(s2_k_q) - SW'(BPP);

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_o     <= 1'b0;
      scale_o    <= '0;
      fraction_o <= '0;
      guard_o    <= 1'b0;
      sticky_o   <= 1'b0;
      zero_o     <= 1'b0;
      NaR_o      <= 1'b0;
      sow_o      <= 1'b0;
      eow_o      <= 1'b0;
    end else if (pe && vld_q[1]) begin
      sow_o <= s2_sow_q;
      eow_o <= s2_eow_q;
      NaR_o <= s2_nar_q;
      if (s2_nar_q || s2_zero_q) begin
        sign_o     <= 1'b0;
        scale_o    <= '0;
        fraction_o <= '0;
        guard_o    <= 1'b0;
        sticky_o   <= 1'b0;
        zero_o     <= ~s2_nar_q;
      end else begin
        sign_o     <= s2_sign_q;
        scale_o    <= scale_d;
        fraction_o <= norm[Q-2 -: F];
        guard_o    <= norm[Q-2-F];
        sticky_o   <= |norm[Q-3-F:0];
        zero_o     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_quire_to_posit_norm.sv
// Randomized bench for quire_to_posit_norm against an arithmetic reference model.
module tb_quire_to_posit_norm;
  localparam int Q   = 35;
  localparam int F   = 5;
  localparam int SW  = 7;
  localparam int BPP = 12;
  localparam int EW  = 4 + SW + F + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0, NaR_i = 1'b0;
  logic [Q-1:0]  data_i = '0;
  logic          rtr_i = 1'b1;
  logic          rtr_o, rts_o, sow_o, eow_o, sign_o, guard_o, sticky_o, zero_o, NaR_o;
  logic signed [SW-1:0] scale_o;
  logic [F-1:0]  fraction_o;

  int nchk = 0, nerr = 0;
  int bp_mode = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs, held;
  logic          stall_v = 1'b0;

  quire_to_posit_norm dut (
    .clk(clk), .rst(rst), .rts_i(rts_i), .rtr_o(rtr_o), .sow_i(sow_i), .eow_i(eow_i),
    .data_i(data_i), .NaR_i(NaR_i), .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o),
    .eow_o(eow_o), .sign_o(sign_o), .scale_o(scale_o), .fraction_o(fraction_o),
    .guard_o(guard_o), .sticky_o(sticky_o), .zero_o(zero_o), .NaR_o(NaR_o)
  );

  always #5 clk = ~clk;

  assign obs = {NaR_o, zero_o, sign_o, scale_o, fraction_o, guard_o, sticky_o, sow_o, eow_o};

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    nchk++;
    if (o !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  // Value-level model: interpret the quire as a signed integer and read fields off |v|.
  function automatic logic [EW-1:0] model(input logic [Q-1:0] d, input logic nar,
                                          input logic s, input logic e);
    longint v, mag;
    int k;
    logic [SW-1:0] sc;
    logic [F-1:0]  fr;
    logic g, st;
    if (nar) return {1'b1, {(EW-3){1'b0}}, s, e};
    v = longint'(d);
    if (d[Q-1]) v = v - (longint'(1) << Q);
    mag = (v < 0) ? -v : v;
    if (mag == 0) return {1'b0, 1'b1, {(EW-4){1'b0}}, s, e};
    k = 0;
    while ((mag >> (k + 1)) != 0) k++;
    if (k >= F) fr = F'((mag >> (k - F)) & 31);
    else        fr = F'((mag << (F - k)) & 31);
    g  = (k - F - 1 >= 0) ? (((mag >> (k - F - 1)) & 1) != 0) : 1'b0;
    st = (k - F - 1 > 0) ? ((mag % (longint'(1) << (k - F - 1))) != 0) : 1'b0;
    sc = SW'(k - BPP);
    return {1'b0, 1'b0, (v < 0), sc, fr, g, st, s, e};
  endfunction

  function automatic logic [Q-1:0] rnd_data();
    logic [63:0]  r = {$urandom(), $urandom()};
    logic [Q-1:0] d = r[Q-1:0];
    d = d >> $urandom_range(0, Q);
    if ($urandom_range(0, 1) == 1) d = -d;
    return d;
  endfunction

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       rtr_i = 1'b1;
      1:       rtr_i = ($urandom_range(0, 3) != 0);
      default: rtr_i = 1'b0;
    endcase
  end

  // Scoreboard: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_v = 1'b0;
    end else begin
      if (stall_v && rts_o) chk("stable", obs, held);
      if (rts_o && rtr_i) begin
        if (exp_q.size() == 0) chk("spurious", 1, 0);
        else chk("word", obs, exp_q.pop_front());
      end
      if (rts_i && rtr_o) exp_q.push_back(model(data_i, NaR_i, sow_i, eow_i));
      stall_v = rts_o && !rtr_i;
      held    = obs;
    end
  end

  task automatic send(input logic [Q-1:0] d, input logic nar, input logic s, input logic e);
    logic a = 1'b0;
    int n = 0;
    rts_i = 1'b1; data_i = d; NaR_i = nar; sow_i = s; eow_i = e;
    while (!a && n < 200) begin
      @(negedge clk); a = rtr_o;
      @(posedge clk); #1; n++;
    end
    if (!a) chk("send_timeout", 0, 1);
    rts_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [Q-1:0] t;
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rtr", rtr_o, 0);
    chk("rst_rts", rts_o, 0);
    chk("rst_out", obs, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("rtr_lag", rtr_o, 0);
    @(negedge clk); chk("rtr_rise", rtr_o, 1);
    @(posedge clk); #1;

    // Latency and exact fields for 1.0.
    send(Q'(1 << 12), 1'b0, 1'b1, 1'b1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rts_o && lat < 10);
    chk("latency", lat, 3);
    chk("one_fields", obs, {1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    @(posedge clk); #1;

    // Corner cases, back to back.
    t = Q'(3 << 12); t = -t;
    send(t, 1'b0, 1'b1, 1'b0);
    send(Q'(35'h105), 1'b0, 1'b0, 1'b0);
    send(Q'(1), 1'b0, 1'b0, 1'b1);
    t = '0; t[Q-1] = 1'b1;
    send(t, 1'b0, 1'b1, 1'b1);
    send('0, 1'b0, 1'b0, 1'b0);
    send(Q'(7), 1'b1, 1'b1, 1'b0);
    drain();

    // Stream of 8 with a 5-cycle downstream stall mid-stream.
    fork
      for (int i = 0; i < 8; i++) send(rnd_data(), 1'b0, (i == 0), (i == 7));
      begin repeat (4) @(posedge clk); bp_mode = 2; repeat (5) @(posedge clk); bp_mode = 0; end
    join
    drain();

    // Reset with three words in flight.
    for (int i = 0; i < 3; i++) send(rnd_data(), 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rts", rts_o, 0);
    chk("rst_mid_rtr", rtr_o, 0);
    @(negedge clk); chk("rst_mid_rtr_rise", rtr_o, 1);
    repeat (6) begin @(negedge clk); chk("no_stale", rts_o, 0); end
    @(posedge clk); #1;

    // Random traffic with random backpressure and gaps.
    bp_mode = 1;
    for (int i = 0; i < 400; i++) begin
      send(rnd_data(), ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    bp_mode = 0;
    drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
